// File: rtl/jtframe_ioctl_gen.sv
// ROM-download stimulus generator: paced ioctl write stream with LFSR data,
// linear addresses, ack wait with timeout and sticky done/err reporting.
module jtframe_ioctl_gen #(
    parameter int          AW       = 26,
    parameter int          DW       = 8,
    parameter int          LEN      = 2**AW,
    parameter int          GAP      = 31,
    parameter int          ACK_MASK = 1,
    parameter int          TIMEOUT  = 1023,
    parameter logic [28:0] SEED     = 29'd1
)(
    input  logic          rst,
    input  logic          clk,
    input  logic          start,
    input  logic          stall,
    input  logic          sdram_ack,
    output logic          ioctl_rom,
    output logic [AW-1:0] ioctl_addr,
    output logic [DW-1:0] ioctl_dout,
    output logic          ioctl_wr,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   wr_cnt
);

    localparam int GW = $clog2(GAP + 1);
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    // Completion is detected on the write count so LEN==2**AW works with a wrapping address
    localparam logic [AW:0] NWR = (AW+1)'(LEN / (DW/8));

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_WR, S_ACK, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t        state;
    logic [28:0]   lfsr;
    logic [28:0]   lfsr_nx;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          ack_needed;

    assign lfsr_nx    = {lfsr[0], lfsr[28], lfsr[27] ^ lfsr[0], lfsr[26:1]};
    assign ack_needed = (ioctl_addr & AW'(ACK_MASK)) == AW'(ACK_MASK);
    assign busy       = ioctl_rom;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            lfsr       <= SEED;
            gap_cnt    <= '0;
            tmo_cnt    <= '0;
            ioctl_rom  <= 1'b0;
            ioctl_addr <= '0;
            ioctl_dout <= '0;
            ioctl_wr   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            wr_cnt     <= '0;
        end else begin
            ioctl_wr <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_GAP;
                        gap_cnt    <= GW'(GAP);
                        ioctl_addr <= '0;
                        wr_cnt     <= '0;
                        lfsr       <= SEED;
                        ioctl_dout <= SEED[DW-1:0];
                        ioctl_rom  <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (!stall) begin
                        if (gap_cnt == '0) begin
                            state    <= S_WR;
                            ioctl_wr <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                end
                S_WR: begin
                    // Data for the next write is presented as the strobe drops
                    wr_cnt     <= wr_cnt + 1'b1;
                    lfsr       <= lfsr_nx;
                    ioctl_dout <= lfsr_nx[DW-1:0];
                    tmo_cnt    <= '0;
                    state      <= ack_needed ? S_ACK : S_NEXT;
                end
                S_ACK: begin
                    if (sdram_ack) begin
                        state <= S_NEXT;
                    end else if (tmo_cnt == TW'(TIMEOUT)) begin
                        state     <= S_ERR;
                        ioctl_rom <= 1'b0;
                        err       <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    ioctl_addr <= ioctl_addr + AW'(DW/8);
                    if (wr_cnt == NWR) begin
                        state     <= S_DONE;
                        ioctl_rom <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        state   <= S_GAP;
                        gap_cnt <= GW'(GAP);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
